observer_pulse_pio: RTL and testbench

Parametrised Avalon-MM output-port register for system and subsystem reset and strobe lines in the Observer CPU. It extends the single-bit level output with per-bit set/clear, WIDTH output channels and a self-timed pulse mode: each channel's pulse auto-deasserts after a programmable number of clocks. Sticky per-channel done flags let firmware confirm that a reset or strobe pulse has completed.

---
 rtl/observer_pulse_pio.sv | 82 ++++++++
 tb/tb_observer_pulse_pio.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/observer_pulse_pio.sv
// observer_pulse_pio: Avalon-MM output port with level set/clear and self-timed per-channel pulses.
// out_port = DATA | busy; sticky done flags record pulse completion.
module observer_pulse_pio #(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               DEFAULT_LEN = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic             wr_strobe;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] pulse_len;
    logic [CNT_W-1:0] eff_len;
    logic [WIDTH-1:0] busy;
    logic [WIDTH-1:0] done;
    logic [WIDTH-1:0] trig;
    logic [WIDTH-1:0] done_clr;
    logic [CNT_W-1:0] count [WIDTH];
    logic             unused_bits;

    assign wr_strobe   = chipselect & ~write_n;
    assign eff_len     = (pulse_len == '0) ? CNT_W'(1) : pulse_len;
    assign trig        = (wr_strobe && address == 3'd2) ? writedata[WIDTH-1:0] : '0;
    assign done_clr    = (wr_strobe && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
    assign out_port    = data | busy;
    assign unused_bits = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data      <= RESET_VALUE;
            pulse_len <= CNT_W'(DEFAULT_LEN);
        end else if (wr_strobe) begin
            if (address == 3'd0) data <= writedata[WIDTH-1:0];
            if (address == 3'd1) pulse_len <= writedata[CNT_W-1:0];
            if (address == 3'd4) data <= data | writedata[WIDTH-1:0];
            if (address == 3'd5) data <= data & ~writedata[WIDTH-1:0];
        end
    end

    // Retrigger has priority over expiry; expiry's done set beats a same-edge W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
            done <= '0;
            for (int i = 0; i < WIDTH; i++) count[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (trig[i]) begin
                    busy[i]  <= 1'b1;
                    count[i] <= eff_len;
                    done[i]  <= 1'b0;
                end else if (busy[i] && count[i] == CNT_W'(1)) begin
                    busy[i]  <= 1'b0;
                    count[i] <= '0;
                    done[i]  <= 1'b1;
                end else begin
                    if (busy[i]) count[i] <= count[i] - CNT_W'(1);
                    if (done_clr[i]) done[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[WIDTH-1:0] = out_port;
            3'd1:    readdata[CNT_W-1:0] = pulse_len;
            3'd2:    readdata[WIDTH-1:0] = busy;
            3'd3:    readdata[WIDTH-1:0] = done;
            default: readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_observer_pulse_pio.sv
// tb_observer_pulse_pio: directed self-checking bench for observer_pulse_pio.
module tb_observer_pulse_pio;
    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    int          total;
    int          bad;

    observer_pulse_pio #(.WIDTH(8), .CNT_W(16), .RESET_VALUE(8'hA5), .DEFAULT_LEN(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset;
        total++;
        if (out_port !== 8'hA5) begin bad++; $display("FAIL reset_out_in_reset got=%h exp=a5", out_port); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (out_port !== 8'hA5) begin bad++; $display("FAIL reset_out got=%h exp=a5", out_port); end
        address = 3'd0; #1; total++;
        if (readdata !== 32'hA5) begin bad++; $display("FAIL reset_rd0 got=%h exp=a5", readdata); end
        address = 3'd1; #1; total++;
        if (readdata !== 32'd16) begin bad++; $display("FAIL reset_rd1 got=%h exp=10", readdata); end
        address = 3'd2; #1; total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL reset_rd2 got=%h exp=0", readdata); end
        address = 3'd3; #1; total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL reset_rd3 got=%h exp=0", readdata); end
    endtask

    task automatic test_level;
        wr(3'd0, 32'h0F); total++;
        if (out_port !== 8'h0F) begin bad++; $display("FAIL level_write got=%h exp=0f", out_port); end
        wr(3'd4, 32'hF0); total++;
        if (out_port !== 8'hFF) begin bad++; $display("FAIL level_set got=%h exp=ff", out_port); end
        wr(3'd5, 32'h3C); total++;
        if (out_port !== 8'hC3) begin bad++; $display("FAIL level_clear got=%h exp=c3", out_port); end
        address = 3'd4; #1; total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL level_rd4 got=%h exp=0", readdata); end
        address = 3'd5; #1; total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL level_rd5 got=%h exp=0", readdata); end
        address = 3'd0; #1; total++;
        if (readdata !== 32'hC3) begin bad++; $display("FAIL level_rd0 got=%h exp=c3", readdata); end
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'h00);
        total++;
        if (out_port !== 8'hC3) begin bad++; $display("FAIL level_unmapped got=%h exp=c3", out_port); end
        address = 3'd6; #1; total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL level_rd6 got=%h exp=0", readdata); end
        wr(3'd0, 32'h00);
    endtask

    task automatic test_pulse_width;
        int n;
        wr(3'd1, 32'd5);
        wr(3'd2, 32'h01);
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            address = 3'd2; #1;
            if (k == 1) begin
                total++;
                if (readdata !== 32'h01) begin bad++; $display("FAIL pulse_busy_rd got=%h exp=01", readdata); end
            end
            if (out_port[0]) n++;
        end
        total++;
        if (n != 5) begin bad++; $display("FAIL pulse_len5 got=%0d exp=5", n); end
        address = 3'd3; #1; total++;
        if (readdata !== 32'h01) begin bad++; $display("FAIL pulse_done got=%h exp=01", readdata); end
        address = 3'd2; #1; total++;
        if (readdata !== 32'h00) begin bad++; $display("FAIL pulse_busy_end got=%h exp=00", readdata); end
        wr(3'd3, 32'h01);
        address = 3'd3; #1; total++;
        if (readdata !== 32'h00) begin bad++; $display("FAIL pulse_w1c got=%h exp=00", readdata); end
        wr(3'd1, 32'd0);
        wr(3'd2, 32'h01);
        n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (out_port[0]) n++;
        end
        total++;
        if (n != 1) begin bad++; $display("FAIL pulse_len0 got=%0d exp=1", n); end
        wr(3'd3, 32'hFF);
    endtask

    task automatic test_retrigger;
        int n;
        wr(3'd1, 32'd4);
        wr(3'd2, 32'h04);
        n = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            chipselect = 1'b0; write_n = 1'b1;
            if (out_port[2]) n++;
            if (k == 3) begin address = 3'd2; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0; end
            if (k == 7) begin address = 3'd3; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0; end
        end
        total++;
        if (n != 7) begin bad++; $display("FAIL retrig_len got=%0d exp=7", n); end
        address = 3'd3; #1; total++;
        if (readdata !== 32'h04) begin bad++; $display("FAIL retrig_w1c_race got=%h exp=04", readdata); end
        wr(3'd3, 32'hFF);
    endtask

    task automatic test_len_latch;
        int b1, b3;
        wr(3'd1, 32'd10);
        wr(3'd2, 32'h02);
        b1 = 0; b3 = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chipselect = 1'b0; write_n = 1'b1; address = 3'd2; #1;
            if (readdata[1]) b1++;
            if (readdata[3]) b3++;
            if (k == 1) begin address = 3'd1; writedata = 32'd2; chipselect = 1'b1; write_n = 1'b0; end
            if (k == 2) begin address = 3'd2; writedata = 32'h08; chipselect = 1'b1; write_n = 1'b0; end
            if (k == 4) begin address = 3'd4; writedata = 32'h02; chipselect = 1'b1; write_n = 1'b0; end
        end
        total++;
        if (b1 != 10) begin bad++; $display("FAIL latch_bit1 got=%0d exp=10", b1); end
        total++;
        if (b3 != 2) begin bad++; $display("FAIL latch_bit3 got=%0d exp=2", b3); end
        total++;
        if (out_port !== 8'h02) begin bad++; $display("FAIL latch_data_hold got=%h exp=02", out_port); end
        address = 3'd3; #1; total++;
        if (readdata !== 32'h0A) begin bad++; $display("FAIL latch_done got=%h exp=0a", readdata); end
    endtask

    task automatic test_async_reset;
        wr(3'd0, 32'h00);
        wr(3'd1, 32'd8);
        wr(3'd2, 32'h10);
        @(negedge clk);
        #2; total++;
        if (out_port !== 8'h10) begin bad++; $display("FAIL arst_pre got=%h exp=10", out_port); end
        reset_n = 1'b0;
        #1; total++;
        if (out_port !== 8'hA5) begin bad++; $display("FAIL arst_immediate got=%h exp=a5", out_port); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (out_port !== 8'hA5) begin bad++; $display("FAIL arst_residual got=%h exp=a5", out_port); end
        address = 3'd2; #1; total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL arst_busy got=%h exp=0", readdata); end
        address = 3'd3; #1; total++;
        if (readdata !== 32'd0) begin bad++; $display("FAIL arst_done got=%h exp=0", readdata); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
        #12;
        test_reset;
        test_level;
        test_pulse_width;
        test_retrigger;
        test_len_latch;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
